key_entry_sequencer: RTL and testbench
======================================

KEY_ENTRY_SEQUENCER -- requirements
Module: key_entry_sequencer

Interface
REQ-001 Parameter KEY_INIT, default 8'h00: stored key value loaded at reset.
REQ-002 Parameter MAX_TRIES, default 3: consecutive failed compares that trigger lockout; legal range 1..3.
REQ-003 Parameter LOCK_CYCLES, default 16: lockout duration in clk cycles; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  one-cycle qualifier for in_nibble.
REQ-007 in_nibble  input  4  keypad digit; first accepted nibble is the high nibble, second is the low nibble.
REQ-008 prog_mode  input  1  when high on low-nibble acceptance, the entry is stored as the new key instead of being compared.
REQ-009 clear  input  1  aborts a partial entry.
REQ-010 match  input  1  downstream compare result, high for exactly the one cycle after read_strobe when entry equals key.
REQ-011 data_1  output  8  last completed entry, registered.
REQ-012 data_2  output  8  stored key, registered.
REQ-013 read_strobe  output  1  one-cycle compare request to the downstream comparator.
REQ-014 unlocked  output  1  one-cycle pulse on successful compare.
REQ-015 key_loaded  output  1  one-cycle pulse when a new key is stored.
REQ-016 locked  output  1  high throughout lockout.
REQ-017 fail_count  output  2  current consecutive-failure count.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 The block SHALL implement states IDLE, HAVE_HI, STROBE, CHECK, LOCKED.
REQ-020 IDLE: in_valid SHALL latch in_nibble into hi register and move to HAVE_HI.
REQ-021 HAVE_HI: clear SHALL return to IDLE with data_1 unchanged, taking priority over a simultaneous in_valid.
REQ-022 HAVE_HI with in_valid and prog_mode: data_2 SHALL load {hi,in_nibble}, key_loaded SHALL pulse next cycle, fail_count SHALL clear, state SHALL return to IDLE; read_strobe SHALL NOT assert.
REQ-023 HAVE_HI with in_valid and not prog_mode: data_1 SHALL load {hi,in_nibble} and state SHALL move to STROBE.
REQ-024 STROBE: read_strobe SHALL be 1 for exactly this one cycle, with data_1 and data_2 stable; next state CHECK.
REQ-025 CHECK: match SHALL be sampled; match=1 -> unlocked pulses next cycle, fail_count clears, state IDLE.
REQ-026 CHECK with match=0: fail_count increments; if the new value equals MAX_TRIES, state SHALL enter LOCKED with lock counter loaded LOCK_CYCLES-1, else IDLE.
REQ-027 LOCKED: locked=1; counter decrements each cycle; at counter 0 state SHALL return to IDLE and fail_count SHALL clear in the same edge; LOCKED SHALL last exactly LOCK_CYCLES cycles.
REQ-028 in_valid, clear and prog_mode SHALL be ignored in STROBE, CHECK and LOCKED; nibbles arriving there are discarded, not queued.
REQ-029 clear in IDLE SHALL have no effect; match outside CHECK SHALL be ignored.
REQ-030 Entry-to-read_strobe latency SHALL be 1 cycle after low-nibble acceptance; read_strobe-to-unlocked latency 2 cycles.

Reset
REQ-031 On reset: state IDLE, data_1=8'h00, data_2=KEY_INIT, fail_count=0, lock counter=0, all pulse outputs and locked/busy 0.
REQ-032 Reset SHALL override every state, including mid-entry and mid-lockout, taking effect on the same edge.

Verification
REQ-033 Default key: nibbles 0,0 -> read_strobe one cycle, data_1=8'h00; match=1 next cycle -> unlocked pulse, fail_count=0.
REQ-034 Program: prog_mode=1, nibbles A,5 -> data_2=8'hA5, key_loaded pulse, no read_strobe; then nibbles A,5 with match=1 -> unlocked.
REQ-035 Three entries of 8'h12 with match=0 -> fail_count 1,2, then locked=1 for exactly 16 cycles; nibbles during lockout ignored; fail_count=0 after.
REQ-036 Nibble 7, clear and in_valid (nibble 3) same cycle -> IDLE, no read_strobe, data_1 unchanged.
REQ-037 Reset asserted on cycle 5 of lockout -> locked=0, data_2=KEY_INIT, fail_count=0 next cycle.

Source files
------------

// File: rtl/key_entry_sequencer.sv
// Key entry sequencer: collects two keypad nibbles into a byte, then either
// stores the byte as the new key (program mode) or hands it to a downstream
// comparator and reacts to its match result. After too many consecutive
// mismatches the block refuses input for a fixed number of cycles.
module key_entry_sequencer #(
    parameter logic [7:0] KEY_INIT    = 8'h00,
    parameter int         MAX_TRIES   = 3,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_nibble,
    input  logic       prog_mode,
    input  logic       clear,
    input  logic       match,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic       read_strobe,
    output logic       unlocked,
    output logic       key_loaded,
    output logic       locked,
    output logic [1:0] fail_count,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HAVE_HI = 3'd1,
        STROBE  = 3'd2,
        CHECK   = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    localparam logic [1:0]  MAX_TRIES_L = 2'(MAX_TRIES);
    localparam logic [15:0] LOCK_LOAD   = 16'(LOCK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  hi_q, hi_d;
    logic [7:0]  data1_q, data1_d;
    logic [7:0]  data2_q, data2_d;
    logic [1:0]  fail_q, fail_d;
    logic [15:0] lockCnt_q, lockCnt_d;
    logic        unlocked_q, unlocked_d;
    logic        keyLoaded_q, keyLoaded_d;
    logic [1:0]  failInc;

    // Next-state logic: every register holds by default, pulse flags default low.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        fail_d      = fail_q;
        lockCnt_d   = lockCnt_q;
        unlocked_d  = 1'b0;
        keyLoaded_d = 1'b0;
        failInc     = 2'(fail_q + 2'd1);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hi_d    = in_nibble;
                    state_d = HAVE_HI;
                end
            end
            HAVE_HI: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    if (prog_mode) begin
                        data2_d     = {hi_q, in_nibble};
                        keyLoaded_d = 1'b1;
                        fail_d      = 2'd0;
                        state_d     = IDLE;
                    end else begin
                        data1_d = {hi_q, in_nibble};
                        state_d = STROBE;
                    end
                end
            end
            STROBE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (match) begin
                    unlocked_d = 1'b1;
                    fail_d     = 2'd0;
                    state_d    = IDLE;
                end else begin
                    fail_d = failInc;
                    if (failInc == MAX_TRIES_L) begin
                        lockCnt_d = LOCK_LOAD;
                        state_d   = LOCKED;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (lockCnt_q == 16'd0) begin
                    fail_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    lockCnt_d = lockCnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hi_q        <= 4'h0;
            data1_q     <= 8'h00;
            data2_q     <= KEY_INIT;
            fail_q      <= 2'd0;
            lockCnt_q   <= 16'd0;
            unlocked_q  <= 1'b0;
            keyLoaded_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            fail_q      <= fail_d;
            lockCnt_q   <= lockCnt_d;
            unlocked_q  <= unlocked_d;
            keyLoaded_q <= keyLoaded_d;
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        read_strobe = (state_q == STROBE);
        locked      = (state_q == LOCKED);
        busy        = (state_q != IDLE);
    end

    assign data_1     = data1_q;
    assign data_2     = data2_q;
    assign unlocked   = unlocked_q;
    assign key_loaded = keyLoaded_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Testbench for key_entry_sequencer: a table of per-cycle vectors covering
// default-key unlock, key programming and the path into lockout, followed by
// hand-written sequences for lockout length, clear priority and reset.
module tb_key_entry_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_nibble;
    logic       prog_mode;
    logic       clear;
    logic       match;
    logic [7:0] data_1;
    logic [7:0] data_2;
    logic       read_strobe;
    logic       unlocked;
    logic       key_loaded;
    logic       locked;
    logic [1:0] fail_count;
    logic       busy;

    int checks = 0;
    int failures = 0;

    key_entry_sequencer #(
        .KEY_INIT(8'h00),
        .MAX_TRIES(3),
        .LOCK_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_nibble(in_nibble),
        .prog_mode(prog_mode),
        .clear(clear),
        .match(match),
        .data_1(data_1),
        .data_2(data_2),
        .read_strobe(read_strobe),
        .unlocked(unlocked),
        .key_loaded(key_loaded),
        .locked(locked),
        .fail_count(fail_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  nib;
        logic        pm;
        logic        clr;
        logic        mt;
        logic        rst;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[25];

    // Packs expected outputs: {read_strobe, unlocked, key_loaded, locked, busy, fail_count, data_1, data_2}
    function automatic logic [22:0] ex(input logic rs, input logic ul, input logic kl,
                                       input logic lk, input logic bz, input logic [1:0] fc,
                                       input logic [7:0] d1, input logic [7:0] d2);
        return {rs, ul, kl, lk, bz, fc, d1, d2};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [3:0] nib, input logic pm,
                                input logic clr, input logic mt, input logic rst,
                                input logic [22:0] e);
        vec_t v;
        v.iv = iv; v.nib = nib; v.pm = pm; v.clr = clr; v.mt = mt; v.rst = rst; v.exp = e;
        return v;
    endfunction

    // Drives one cycle of inputs, then waits past the rising edge.
    task automatic applyStimulus(input logic iv, input logic [3:0] nib, input logic pm,
                                 input logic clr, input logic mt, input logic rst);
        in_valid  = iv;
        in_nibble = nib;
        prog_mode = pm;
        clear     = clr;
        match     = mt;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    // Compares the full output bundle against an expected packed value.
    task automatic checkOutput(input string name, input logic [22:0] expv);
        logic [22:0] act;
        act = {read_strobe, unlocked, key_loaded, locked, busy, fail_count, data_1, data_2};
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got rs/ul/kl/lk/bz/fc/d1/d2=%0b%0b%0b%0b%0b %0d %h %h, expected %0b%0b%0b%0b%0b %0d %h %h",
                     name, act[22], act[21], act[20], act[19], act[18], act[17:16], act[15:8], act[7:0],
                     expv[22], expv[21], expv[20], expv[19], expv[18], expv[17:16], expv[15:8], expv[7:0]);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    initial begin
        int lockCount;
        bit sawExit;

        in_valid = 0; in_nibble = 0; prog_mode = 0; clear = 0; match = 0; reset = 1;

        //                iv nib   pm clr mt rst      rs ul kl lk bz fc d1     d2
        vecs[0]  = mk(0, 4'h0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs[1]  = mk(1, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 8'h00, 8'h00));
        vecs[2]  = mk(1, 4'h0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0, 8'h00, 8'h00));
        vecs[3]  = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 8'h00, 8'h00));
        vecs[4]  = mk(0, 4'h0, 0, 0, 1, 0, ex(0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs[5]  = mk(0, 4'h0, 0, 1, 1, 0, ex(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs[6]  = mk(1, 4'hA, 1, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 8'h00, 8'h00));
        vecs[7]  = mk(1, 4'h5, 1, 0, 0, 0, ex(0, 0, 1, 0, 0, 0, 8'h00, 8'hA5));
        vecs[8]  = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 8'h00, 8'hA5));
        vecs[9]  = mk(1, 4'hA, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 8'h00, 8'hA5));
        vecs[10] = mk(1, 4'h5, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0, 8'hA5, 8'hA5));
        vecs[11] = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 8'hA5, 8'hA5));
        vecs[12] = mk(0, 4'h0, 0, 0, 1, 0, ex(0, 1, 0, 0, 0, 0, 8'hA5, 8'hA5));
        vecs[13] = mk(1, 4'h1, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 8'hA5, 8'hA5));
        vecs[14] = mk(1, 4'h2, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0, 8'h12, 8'hA5));
        vecs[15] = mk(1, 4'h9, 1, 1, 0, 0, ex(0, 0, 0, 0, 1, 0, 8'h12, 8'hA5));
        vecs[16] = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 8'h12, 8'hA5));
        vecs[17] = mk(1, 4'h1, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 1, 8'h12, 8'hA5));
        vecs[18] = mk(1, 4'h2, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 1, 8'h12, 8'hA5));
        vecs[19] = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 1, 8'h12, 8'hA5));
        vecs[20] = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 2, 8'h12, 8'hA5));
        vecs[21] = mk(1, 4'h1, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 2, 8'h12, 8'hA5));
        vecs[22] = mk(1, 4'h2, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 2, 8'h12, 8'hA5));
        vecs[23] = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 2, 8'h12, 8'hA5));
        vecs[24] = mk(0, 4'h0, 0, 0, 0, 0, ex(0, 0, 0, 1, 1, 3, 8'h12, 8'hA5));

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].nib, vecs[i].pm, vecs[i].clr, vecs[i].mt, vecs[i].rst);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Lockout length with nibbles hammering the input the whole time.
        lockCount = 1;
        sawExit = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 4'h3, 0, 0, 1, 0);
            if (locked) begin
                lockCount++;
            end else begin
                sawExit = 1;
                break;
            end
        end
        checkValue("lockout_exit_seen", int'(sawExit), 1);
        checkValue("lockout_cycles", lockCount, 16);
        checkOutput("after_lockout", ex(0, 0, 0, 0, 0, 0, 8'h12, 8'hA5));
        applyStimulus(0, 4'h0, 0, 0, 0, 0);
        checkOutput("idle_after_lockout", ex(0, 0, 0, 0, 0, 0, 8'h12, 8'hA5));

        // Clear wins over a simultaneous low nibble.
        applyStimulus(1, 4'h7, 0, 0, 0, 0);
        checkOutput("clear_hi", ex(0, 0, 0, 0, 1, 0, 8'h12, 8'hA5));
        applyStimulus(1, 4'h3, 0, 1, 0, 0);
        checkOutput("clear_prio", ex(0, 0, 0, 0, 0, 0, 8'h12, 8'hA5));
        applyStimulus(0, 4'h0, 0, 0, 0, 0);
        checkOutput("clear_no_strobe", ex(0, 0, 0, 0, 0, 0, 8'h12, 8'hA5));

        // Drive into lockout again, then reset during the fifth lockout cycle.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 4'h3, 0, 0, 0, 0);
            checkOutput($sformatf("fail%0d_hi", k), ex(0, 0, 0, 0, 1, 2'(k - 1), 8'h12 + ((k > 1) ? 8'h22 : 8'h00), 8'hA5));
            applyStimulus(1, 4'h4, 0, 0, 0, 0);
            checkOutput($sformatf("fail%0d_strobe", k), ex(1, 0, 0, 0, 1, 2'(k - 1), 8'h34, 8'hA5));
            applyStimulus(0, 4'h0, 0, 0, 0, 0);
            applyStimulus(0, 4'h0, 0, 0, 0, 0);
            checkOutput($sformatf("fail%0d_result", k), ex(0, 0, 0, (k == 3), (k == 3), 2'(k), 8'h34, 8'hA5));
        end
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(0, 4'h0, 0, 0, 0, 0);
            checkOutput($sformatf("lock_cycle%0d", c), ex(0, 0, 0, 1, 1, 3, 8'h34, 8'hA5));
        end
        applyStimulus(0, 4'h0, 0, 0, 0, 1);
        checkOutput("reset_in_lockout", ex(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        applyStimulus(0, 4'h0, 0, 0, 0, 0);
        checkOutput("idle_after_reset", ex(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
